// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types and constants for the divider sequencer
package div_pkg;

   localparam int DIV_W     = 8;
   localparam int DIV_ITERS = 8;
   localparam logic [DIV_W-1:0] DZ_QUOTIENT = 8'hFF;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_RUN,
      S_CAPTURE,
      S_ZERO
   } div_seq_state_t;

endpackage

// File: rtl/divide.sv
// rtl/divide.sv - 8-bit restoring divider core with hold-high start protocol
module Divide (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] A,
   input  logic [7:0] B,
   output logic [7:0] Q,
   output logic [7:0] R,
   output logic       ok
);

   logic [7:0] dvs;
   logic [3:0] steps;
   logic [8:0] shifted;
   logic [7:0] diff;

   // one restoring step: bring in the next dividend bit and trial-subtract
   always_comb begin
      shifted = {R, Q[7]};
      diff    = shifted[7:0] - dvs;
   end

   // loads when start is seen idle, iterates while start stays high, freezes when low;
   // holding start past completion reloads the operands
   always_ff @(posedge clk) begin
      if (reset) begin
         Q     <= '0;
         R     <= '0;
         dvs   <= '0;
         steps <= '0;
         ok    <= 1'b0;
      end else if (start) begin
         if (steps == 4'd0) begin
            Q     <= A;
            R     <= '0;
            dvs   <= B;
            steps <= 4'd8;
            ok    <= 1'b0;
         end else begin
            if (shifted >= {1'b0, dvs}) begin
               R <= diff;
               Q <= {Q[6:0], 1'b1};
            end else begin
               R <= shifted[7:0];
               Q <= {Q[6:0], 1'b0};
            end
            steps <= steps - 4'd1;
            if (steps == 4'd1) begin
               ok <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - show-ahead synchronous FIFO with full/empty flags
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_wr;
   logic             do_rd;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_wr   = wr_en & ~full;
   assign do_rd   = rd_en & ~empty;
   assign rd_data = mem[rd_ptr];

   // storage array; contents need no reset because count gates every read
   always_ff @(posedge clk) begin
      if (do_wr) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   // pointers and occupancy; power-of-two depth lets pointers wrap naturally
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_wr) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (do_rd) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({do_wr, do_rd})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/div_sequencer.sv
// rtl/div_sequencer.sv - queued front-end driving the restoring divider core
module div_sequencer
   import div_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       in_a,
   input  logic [7:0]       in_b,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [7:0]       out_q,
   output logic [7:0]       out_r,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_dz,
   output logic             div_start,
   output logic [7:0]       div_a,
   output logic [7:0]       div_b,
   input  logic [7:0]       div_q,
   input  logic [7:0]       div_r,
   input  logic             div_ok,
   output logic             proto_err
);

   localparam int FW    = 2*DIV_W + TAG_W;
   localparam int CNT_W = $clog2(DIV_ITERS);

   div_seq_state_t   state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;

   logic             push, pop, fifo_full, fifo_empty;
   logic [FW-1:0]    fifo_wdata, fifo_rdata;
   logic [DIV_W-1:0] head_b;

   logic [DIV_W-1:0] wa, wb;
   logic [TAG_W-1:0] wtag;

   logic             slot_free;
   logic             wr_out, wr_dz;

   assign in_ready   = ~fifo_full;
   assign push       = in_valid & in_ready;
   assign fifo_wdata = {in_a, in_b, in_tag};
   assign head_b     = fifo_rdata[TAG_W +: DIV_W];
   assign slot_free  = ~out_valid | out_ready;
   assign div_a      = wa;
   assign div_b      = wb;

   sync_fifo #(
      .WIDTH (FW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (push),
      .wr_data (fifo_wdata),
      .rd_en   (pop),
      .rd_data (fifo_rdata),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   // state and iteration counter
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
      end
   end

   // next state, pops and core start; start drops in CAPTURE so the core cannot reload
   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      pop       = 1'b0;
      wr_out    = 1'b0;
      wr_dz     = 1'b0;
      div_start = 1'b0;
      case (state)
         S_IDLE: begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               state_n = (head_b == '0) ? S_ZERO : S_LOAD;
            end
         end
         S_LOAD: begin
            div_start = 1'b1;
            cnt_n     = CNT_W'(DIV_ITERS - 1);
            state_n   = S_RUN;
         end
         S_RUN: begin
            div_start = 1'b1;
            if (cnt == '0) begin
               state_n = S_CAPTURE;
            end else begin
               cnt_n = cnt - CNT_W'(1);
            end
         end
         S_CAPTURE: begin
            if (slot_free) begin
               wr_out = 1'b1;
               if (!fifo_empty) begin
                  pop     = 1'b1;
                  state_n = (head_b == '0) ? S_ZERO : S_LOAD;
               end else begin
                  state_n = S_IDLE;
               end
            end
         end
         S_ZERO: begin
            if (slot_free) begin
               wr_out  = 1'b1;
               wr_dz   = 1'b1;
               state_n = S_IDLE;
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   // working operands captured at pop; they also feed the core directly
   always_ff @(posedge clk) begin
      if (reset) begin
         wa   <= '0;
         wb   <= '0;
         wtag <= '0;
      end else if (pop) begin
         {wa, wb, wtag} <= fifo_rdata;
      end
   end

   // result slot: refill wins over drain so back-to-back results never drop
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_q     <= '0;
         out_r     <= '0;
         out_tag   <= '0;
         out_dz    <= 1'b0;
      end else if (wr_out) begin
         out_valid <= 1'b1;
         out_q     <= wr_dz ? DZ_QUOTIENT : div_q;
         out_r     <= wr_dz ? wa : div_r;
         out_tag   <= wtag;
         out_dz    <= wr_dz;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   // sticky flag for a core that has not finished by the time we capture
   always_ff @(posedge clk) begin
      if (reset) begin
         proto_err <= 1'b0;
      end else if (state == S_CAPTURE && !div_ok) begin
         proto_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_div_sequencer.sv
// tb/tb_div_sequencer.sv - scoreboard bench for div_sequencer with the Divide core
module tb_div_sequencer;
   import div_pkg::*;

   localparam int DEPTH = 4;
   localparam int TAG_W = 4;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [7:0]       in_a = '0;
   logic [7:0]       in_b = '0;
   logic [TAG_W-1:0] in_tag = '0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [7:0]       out_q, out_r;
   logic [TAG_W-1:0] out_tag;
   logic             out_dz;
   logic             div_start;
   logic [7:0]       div_a, div_b, div_q, div_r;
   logic             div_ok;
   logic             proto_err;

   int               vectors = 0;
   int               miscompares = 0;
   logic [20:0]      sb [$];
   bit               rand_ready = 1'b0;
   bit               accepted;

   always #5 clk = ~clk;

   div_sequencer #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_q(out_q), .out_r(out_r), .out_tag(out_tag), .out_dz(out_dz),
      .div_start(div_start), .div_a(div_a), .div_b(div_b),
      .div_q(div_q), .div_r(div_r), .div_ok(div_ok),
      .proto_err(proto_err)
   );

   Divide core (
      .clk(clk), .reset(reset), .start(div_start),
      .A(div_a), .B(div_b), .Q(div_q), .R(div_r), .ok(div_ok)
   );

   function automatic logic [20:0] model(input logic [7:0] a, input logic [7:0] b,
                                         input logic [3:0] t);
      logic [7:0] q, r;
      if (b == 8'd0) return {8'hFF, a, t, 1'b1};
      q = a / b;
      r = a % b;
      return {q, r, t, 1'b0};
   endfunction

   // one clock: sample handshakes on the falling edge, then step past the rising edge
   task automatic tick();
      logic [20:0] got, exp;
      accepted = 1'b0;
      @(negedge clk);
      if (!reset && in_valid && in_ready) begin
         sb.push_back(model(in_a, in_b, in_tag));
         accepted = 1'b1;
      end
      if (!reset && out_valid && out_ready) begin
         got = {out_q, out_r, out_tag, out_dz};
         vectors++;
         if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_result: got q=%0d r=%0d tag=%0d dz=%0b, required none",
                     out_q, out_r, out_tag, out_dz);
         end else begin
            exp = sb.pop_front();
            if (got !== exp) begin
               miscompares++;
               $display("FAIL result: got q=%0d r=%0d tag=%0d dz=%0b, required q=%0d r=%0d tag=%0d dz=%0b",
                        out_q, out_r, out_tag, out_dz, exp[20:13], exp[12:5], exp[4:1], exp[0]);
            end
         end
      end
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [3:0] t);
      int n;
      in_a = a; in_b = b; in_tag = t; in_valid = 1'b1;
      n = 0;
      do begin
         tick();
         n++;
      end while (!accepted && n < 300);
      in_valid = 1'b0;
      if (!accepted) begin
         vectors++; miscompares++;
         $display("FAIL send_timeout: got no acceptance in %0d cycles, required acceptance", n);
      end
   endtask

   task automatic wait_drain(input int bound);
      int n;
      n = 0;
      while (sb.size() != 0 && n < bound) begin
         tick();
         n++;
      end
      vectors++;
      if (sb.size() != 0) begin
         miscompares++;
         $display("FAIL drain: got %0d results outstanding, required 0", sb.size());
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      tick(); tick();
      reset = 1'b0;
      vectors++;
      if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
      vectors++;
      if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
      vectors++;
      if ({out_q, out_r, out_tag, out_dz} !== 21'd0) begin
         miscompares++;
         $display("FAIL reset_out_data: got q=%0d r=%0d tag=%0d dz=%b required all 0", out_q, out_r, out_tag, out_dz);
      end
      vectors++;
      if ({div_start, div_a, div_b, proto_err} !== 18'd0) begin
         miscompares++;
         $display("FAIL reset_core_side: got start=%b a=%0d b=%0d perr=%b required all 0", div_start, div_a, div_b, proto_err);
      end
   endtask

   task automatic test_single();
      int n, starts;
      out_ready = 1'b1;
      send(8'd100, 8'd7, 4'd3);
      n = 0; starts = 0;
      while (out_valid !== 1'b1 && n < 40) begin
         tick();
         n++;
         if (div_start === 1'b1) starts++;
      end
      vectors++;
      if (n != 11) begin miscompares++; $display("FAIL single_latency: got %0d required 11", n); end
      vectors++;
      if (starts != 9) begin miscompares++; $display("FAIL single_start_cycles: got %0d required 9", starts); end
      vectors++;
      if ({out_q, out_r, out_tag, out_dz} !== {8'd14, 8'd2, 4'd3, 1'b0}) begin
         miscompares++;
         $display("FAIL single_value: got q=%0d r=%0d tag=%0d dz=%b required 14 2 3 0", out_q, out_r, out_tag, out_dz);
      end
      wait_drain(20);
   endtask

   task automatic test_zero();
      int n, starts;
      out_ready = 1'b1;
      send(8'd55, 8'd0, 4'd1);
      n = 0; starts = 0;
      while (out_valid !== 1'b1 && n < 40) begin
         tick();
         n++;
         if (div_start === 1'b1) starts++;
      end
      vectors++;
      if (n != 2) begin miscompares++; $display("FAIL zero_latency: got %0d required 2", n); end
      vectors++;
      if ({out_q, out_r, out_tag, out_dz} !== {8'hFF, 8'd55, 4'd1, 1'b1}) begin
         miscompares++;
         $display("FAIL zero_value: got q=%0d r=%0d tag=%0d dz=%b required 255 55 1 1", out_q, out_r, out_tag, out_dz);
      end
      for (int i = 0; i < 5; i++) begin
         tick();
         if (div_start === 1'b1) starts++;
      end
      vectors++;
      if (starts != 0) begin miscompares++; $display("FAIL zero_start: got %0d start cycles required 0", starts); end
      wait_drain(20);
   endtask

   task automatic test_burst();
      logic [7:0] ta [5];
      logic [7:0] tb [5];
      ta = '{8'd200, 8'd7, 8'd9, 8'd255, 8'd0};
      tb = '{8'd3, 8'd9, 8'd0, 8'd1, 8'd5};
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) send(ta[i], tb[i], 4'(i));
      vectors++;
      if (in_ready !== 1'b0) begin miscompares++; $display("FAIL burst_full: got in_ready=%b required 0", in_ready); end
      wait_drain(200);
   endtask

   task automatic test_stall();
      logic [20:0] snap;
      bit seen, stable, quiet;
      out_ready = 1'b0;
      send(8'd100, 8'd7, 4'd5);
      send(8'd13, 8'd4, 4'd6);
      seen = 1'b0; stable = 1'b1; quiet = 1'b1; snap = '0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (seen) begin
            if ({out_valid, out_q, out_r, out_tag, out_dz} !== {1'b1, snap}) stable = 1'b0;
         end else if (out_valid === 1'b1) begin
            seen = 1'b1;
            snap = {out_q, out_r, out_tag, out_dz};
         end
         if (i >= 22 && div_start !== 1'b0) quiet = 1'b0;
      end
      vectors++;
      if (snap !== {8'd14, 8'd2, 4'd5, 1'b0}) begin
         miscompares++;
         $display("FAIL stall_first: got q=%0d r=%0d tag=%0d required 14 2 5", snap[20:13], snap[12:5], snap[4:1]);
      end
      vectors++;
      if (!stable) begin miscompares++; $display("FAIL stall_stable: got changing output required stable"); end
      vectors++;
      if (!quiet) begin miscompares++; $display("FAIL stall_start: got div_start high required low"); end
      vectors++;
      if (dut.state !== S_CAPTURE) begin miscompares++; $display("FAIL stall_state: got %0d required %0d", dut.state, S_CAPTURE); end
      out_ready = 1'b1;
      wait_drain(40);
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b1;
      send(8'd100, 8'd7, 4'd2);
      repeat (5) tick();
      vectors++;
      if (dut.state !== S_RUN) begin miscompares++; $display("FAIL mid_run: got state %0d required %0d", dut.state, S_RUN); end
      sb.delete();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      vectors++;
      if (dut.state !== S_IDLE) begin miscompares++; $display("FAIL mid_idle: got state %0d required %0d", dut.state, S_IDLE); end
      vectors++;
      if ({out_valid, in_ready, div_start} !== 3'b010) begin
         miscompares++;
         $display("FAIL mid_flags: got valid=%b ready=%b start=%b required 0 1 0", out_valid, in_ready, div_start);
      end
      send(8'd9, 8'd2, 4'd7);
      wait_drain(40);
   endtask

   task automatic test_random();
      logic [7:0] a, b;
      rand_ready = 1'b1;
      for (int i = 0; i < 500; i++) begin
         a = 8'($urandom_range(0, 255));
         b = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
         send(a, b, 4'($urandom_range(0, 15)));
         if ($urandom_range(0, 3) == 0) tick();
      end
      wait_drain(8000);
      rand_ready = 1'b0;
      out_ready = 1'b1;
      vectors++;
      if (proto_err !== 1'b0) begin miscompares++; $display("FAIL proto_err: got %b required 0", proto_err); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_zero();
      test_burst();
      test_stall();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
